// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Optional feature macro: UART_TX_SCHED_ID_HDR_EN (adds an ID header frame per transaction).
package uart_pkg;

    // Upper nibble of the header byte that announces the requester ID.
    localparam logic [3:0] HDR_MAGIC = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_HI,
        WAIT_LO
`ifdef UART_TX_SCHED_ID_HDR_EN
        ,
        HDR_LAUNCH
`endif
    } state_t;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward, wrapping past NREQ-1 to 0.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Walk offsets from farthest to nearest so the nearest active requester after ptr wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                any = 1'b1;
                idx = IW'((int'(ptr) + k) % NREQ);
            end
        end
        if (any) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one UART transmitter from NREQ byte requesters.
// Optional feature macro: UART_TX_SCHED_ID_HDR_EN -- when defined, every transaction
// is preceded by a header frame {HDR_MAGIC, cur_id} sent from HDR_LAUNCH.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*N-1:0]         req_data,
    output logic [NREQ-1:0]           grant,
    output logic [$clog2(NREQ)-1:0]   cur_id,
    output logic                      busy,
    output logic                      tx_start,
    output logic [N-1:0]              tx_din,
    input  logic                      tx_done
);

    localparam int IW = $clog2(NREQ);

    state_t          state, nxt;
    logic [IW-1:0]   ptr;
    logic [N-1:0]    hold;
    logic [NREQ-1:0] win_oh;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic [N-1:0]    win_data;
    logic            accept;
    logic            frame_end;

`ifdef UART_TX_SCHED_ID_HDR_EN
    logic            hdr_flag;
    logic [7:0]      hdr_byte;
`endif

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );

    assign accept    = (state == IDLE) && win_any;
    assign frame_end = (state == WAIT_LO) && !tx_done;

    // Select the winning slice using the one-hot grant vector.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) win_data = req_data[i*N +: N];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state logic; tx_done is only looked at in the two wait states.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (win_any) begin
`ifdef UART_TX_SCHED_ID_HDR_EN
                    nxt = HDR_LAUNCH;
`else
                    nxt = LAUNCH;
`endif
                end
            end
            LAUNCH:  nxt = WAIT_HI;
`ifdef UART_TX_SCHED_ID_HDR_EN
            HDR_LAUNCH: nxt = WAIT_HI;
`endif
            WAIT_HI: if (tx_done) nxt = WAIT_LO;
            WAIT_LO: begin
                if (!tx_done) begin
`ifdef UART_TX_SCHED_ID_HDR_EN
                    nxt = hdr_flag ? LAUNCH : IDLE;
`else
                    nxt = IDLE;
`endif
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Capture the winner's byte and ownership on acceptance; ptr remembers the last winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= IW'(NREQ - 1);
            hold   <= '0;
            cur_id <= '0;
`ifdef UART_TX_SCHED_ID_HDR_EN
            hdr_flag <= 1'b0;
`endif
        end else begin
            if (accept) begin
                hold   <= win_data;
                cur_id <= win_idx;
                ptr    <= win_idx;
            end
`ifdef UART_TX_SCHED_ID_HDR_EN
            // Flag marks the header frame in flight; cleared once that frame completes.
            if (accept)         hdr_flag <= 1'b1;
            else if (frame_end) hdr_flag <= 1'b0;
`endif
        end
    end

    // Moore outputs decoded from state; the first launch state of a transaction carries the grant.
    always_comb begin
        grant    = '0;
        busy     = (state != IDLE);
        tx_start = 1'b0;
        tx_din   = hold;
`ifdef UART_TX_SCHED_ID_HDR_EN
        hdr_byte = {HDR_MAGIC, 4'(cur_id)};
        if (hdr_flag) tx_din = N'(hdr_byte);
        if (state == HDR_LAUNCH) begin
            tx_start      = 1'b1;
            grant[cur_id] = 1'b1;
        end
        if (state == LAUNCH) tx_start = 1'b1;
`else
        if (state == LAUNCH) begin
            tx_start      = 1'b1;
            grant[cur_id] = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched (N=8, NREQ=4).
// Header scenario runs only when UART_TX_SCHED_ID_HDR_EN is defined.
module tb_uart_tx_sched;

    localparam int N    = 8;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   grant;
    logic [1:0]        cur_id;
    logic              busy;
    logic              tx_start;
    logic [N-1:0]      tx_din;
    logic              tx_done;

    int checks   = 0;
    int failures = 0;
    int starts   = 0;

    uart_tx_sched #(.N(N), .NREQ(NREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .cur_id   (cur_id),
        .busy     (busy),
        .tx_start (tx_start),
        .tx_din   (tx_din),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (tx_start) starts++;
    endtask

    // Complete a frame from the LAUNCH cycle: WAIT_HI, stop bit high, then low -> IDLE.
    task automatic finish_frame();
        tick();
        tx_done = 1'b1;
        tick();
        tick();
        tx_done = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = '0; req_data = '0; tx_done = 1'b0;
        do_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        checks++; if (tx_din !== 8'h00) begin failures++; $display("FAIL reset_tx_din got=%h exp=00", tx_din); end
        checks++; if (cur_id !== 2'd0) begin failures++; $display("FAIL reset_cur_id got=%0d exp=0", cur_id); end
    endtask

    task automatic test_single();
        req_data = 32'h0000_0055;
        req = 4'b0001;
        tick();
        checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", tx_start); end
        checks++; if (tx_din !== 8'h55) begin failures++; $display("FAIL single_din got=%h exp=55", tx_din); end
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", grant); end
        req = 4'b0000;
        tick();
        checks++; if (tx_start !== 1'b0 || grant !== 4'b0000) begin failures++; $display("FAIL single_pulse got=%b/%b exp=0/0000", tx_start, grant); end
        // Stop bit asserted: still busy, data stable.
        tx_done = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b1 || tx_din !== 8'h55) begin failures++; $display("FAIL single_wait got=%b/%h exp=1/55", busy, tx_din); end
        tx_done = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", busy); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_din [5];
        logic [3:0] exp_gnt [5];
        exp_din = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req_data = 32'h4433_2211;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (grant !== exp_gnt[k] || tx_din !== exp_din[k] || tx_start !== 1'b1) begin
                failures++; $display("FAIL rr_%0d got=%b/%h/%b exp=%b/%h/1", k, grant, tx_din, tx_start, exp_gnt[k], exp_din[k]);
            end
            finish_frame();
        end
        req = '0;
    endtask

    task automatic test_busy_ignore();
        int s0;
        do_reset();
        req_data = 32'h00CC_00AA;
        req = 4'b0001;
        tick();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL busy_first_grant got=%b exp=0001", grant); end
        s0 = starts;
        req = 4'b0100;
        tick();
        tick();
        tx_done = 1'b1;
        tick();
        tick();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL busy_no_grant got=%b exp=0000", grant); end
        tx_done = 1'b0;
        tick();
        checks++; if (starts != s0 || busy !== 1'b0) begin failures++; $display("FAIL busy_no_restart got=%0d/%b exp=%0d/0", starts, busy, s0); end
        tick();
        checks++; if (grant !== 4'b0100 || cur_id !== 2'd2 || tx_din !== 8'hCC) begin
            failures++; $display("FAIL busy_next got=%b/%0d/%h exp=0100/2/cc", grant, cur_id, tx_din);
        end
        req = '0;
        finish_frame();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_data = 32'h0000_00E7;
        req = 4'b0001;
        tick();
        finish_frame();
        checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b/%b exp=0/0", busy, tx_start); end
        tick();
        checks++; if (tx_start !== 1'b1 || grant !== 4'b0001) begin failures++; $display("FAIL b2b_second got=%b/%b exp=1/0001", tx_start, grant); end
        req = '0;
        finish_frame();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_data = 32'h0000_BB77;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0011;
        checks++; if (busy !== 1'b0 || grant !== 4'b0000 || tx_start !== 1'b0 || tx_din !== 8'h00 || cur_id !== 2'd0) begin
            failures++; $display("FAIL rstmid_outputs got=%b/%b/%b/%h/%0d exp=0/0000/0/00/0", busy, grant, tx_start, tx_din, cur_id);
        end
        tick();
        checks++; if (grant !== 4'b0001 || tx_din !== 8'h77) begin failures++; $display("FAIL rstmid_regrant got=%b/%h exp=0001/77", grant, tx_din); end
        req = '0;
        finish_frame();
    endtask

    task automatic test_idle_glitch();
        int s0;
        do_reset();
        s0 = starts;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || starts != s0) begin failures++; $display("FAIL glitch_idle got=%b/%0d exp=0/%0d", busy, starts, s0); end
        req_data = 32'h0000_0042;
        req = 4'b0001;
        tick();
        checks++; if (tx_start !== 1'b1 || tx_din !== 8'h42) begin failures++; $display("FAIL glitch_launch got=%b/%h exp=1/42", tx_start, tx_din); end
        req = '0;
        finish_frame();
    endtask

`ifdef UART_TX_SCHED_ID_HDR_EN
    task automatic test_header();
        int g;
        do_reset();
        req_data = 32'h3C00_0000;
        req = 4'b1000;
        tick();
        checks++; if (tx_start !== 1'b1 || tx_din !== 8'hA3 || grant !== 4'b1000) begin
            failures++; $display("FAIL hdr_first got=%b/%h/%b exp=1/a3/1000", tx_start, tx_din, grant);
        end
        req = '0;
        g = 0;
        tick();
        if (grant != 0) g++;
        tx_done = 1'b1;
        tick();
        if (grant != 0) g++;
        tx_done = 1'b0;
        tick();
        checks++; if (tx_start !== 1'b1 || tx_din !== 8'h3C || grant !== 4'b0000 || g != 0) begin
            failures++; $display("FAIL hdr_payload got=%b/%h/%b/%0d exp=1/3c/0000/0", tx_start, tx_din, grant, g);
        end
        finish_frame();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hdr_done got=%b exp=0", busy); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef UART_TX_SCHED_ID_HDR_EN
        test_header();
`else
        test_single();
        test_round_robin();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_idle_glitch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter N, default 8, meaning data byte width and matching transmitter payload width.
REQ-002 Parameter NREQ, default 4, meaning number of requesters (2..16).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req  input  NREQ  per-requester level request; req[i] high means req_data slice i is valid.
REQ-007 req_data  input  NREQ*N  packed bytes; slice i at bits [i*N +: N].
REQ-008 grant  output  NREQ  one-hot, one-cycle acceptance pulse; the slice is consumed on this cycle.
REQ-009 cur_id  output  $clog2(NREQ)  index of requester owning the transmitter; held until the frame ends.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-012 tx_din  output  N  byte presented to the transmitter; stable from tx_start until the frame ends.
REQ-013 tx_done  input  1  transmitter stop-phase level, high for the whole stop bit.

Function
REQ-014 States SHALL be IDLE, LAUNCH, WAIT_HI and WAIT_LO, plus HDR_LAUNCH when the header feature is enabled.
REQ-015 IDLE: when any req bit is high, pick a winner round-robin, searching from ptr+1 upward with wrap past NREQ-1 to 0.
REQ-016 IDLE: on the same edge, latch the winner's slice into the hold register, set cur_id to the winner, and set ptr to the winner.
REQ-017 IDLE: on the same edge, go to LAUNCH, or to HDR_LAUNCH when the header feature is enabled.
REQ-018 LAUNCH SHALL assert tx_start=1 and tx_din=hold for exactly one cycle, then go to WAIT_HI.
REQ-019 grant[cur_id] SHALL pulse in the first launch cycle of a transaction (LAUNCH, or HDR_LAUNCH when enabled), and only there.
REQ-020 Latency from req sampled high in IDLE to tx_start high SHALL be exactly one cycle.
REQ-021 WAIT_HI SHALL stay until tx_done==1, then go to WAIT_LO.
REQ-022 WAIT_LO SHALL stay until tx_done==0, then go to IDLE; with the header pending, it goes to LAUNCH instead.
REQ-023 tx_done SHALL be ignored in IDLE and in the launch states.
REQ-024 Requests changing while busy SHALL be ignored; re-arbitration happens only in IDLE.
REQ-025 A requester holding req high SHALL be granted again only after every other active requester has been served once.
REQ-026 With a single active requester, back-to-back frames SHALL be separated by exactly one IDLE cycle after tx_done falls.
REQ-027 tx_start SHALL never be asserted twice within one frame.

Reset
REQ-028 On rst: state=IDLE, ptr=NREQ-1 (requester 0 wins first), hold=0, cur_id=0, grant=0, tx_start=0, tx_din=0, busy=0, header flag=0.
REQ-029 Reset mid-frame SHALL abandon the frame with no grant and no tx_start on the reset-release cycle.

Configuration
REQ-030 Macro UART_TX_SCHED_ID_HDR_EN defined: each transaction first sends a header byte {HDR_MAGIC (4'hA), cur_id zero-extended to 4 bits} via HDR_LAUNCH.
REQ-031 With the macro defined, the header frame's WAIT_HI/WAIT_LO completes first, then LAUNCH sends the payload from hold; grant pulses in HDR_LAUNCH.
REQ-032 Macro undefined: HDR_LAUNCH and the header flag SHALL not exist, and each transaction is one frame.

Structure
REQ-033 Package uart_pkg SHALL hold the state enum typedef and the HDR_MAGIC constant.
REQ-034 Sub-module rr_arbiter (purely combinational: req, ptr -> one-hot winner and index, any) SHALL be instantiated once.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- req=4'b0001, data0=8'h55 -> tx_start one cycle later with tx_din=8'h55, grant=4'b0001 same cycle, busy until one cycle after tx_done falls.
- req=4'b1111 held -> grant order 0,1,2,3,0 and tx_din sequence matches the slices.
- req=4'b0100 raised while busy on requester 0 -> no second tx_start; 2 granted next IDLE.
- Header enabled, req=4'b1000, data=8'h3C -> tx_din 8'hA3 then 8'h3C, one grant, two tx_start pulses.
- rst during WAIT_HI -> all outputs 0, busy 0, next grant goes to requester 0.
- tx_done glitch high while IDLE -> no state change, no tx_start.
